trig_sequencer: RTL
===================

// Module: trig_sequencer
// PURPOSE
//  Sequences the 64-channel sum trigger into the readout. Takes single-cycle trigger pulses from the sum calculator.
//  Qualifies them with enable and dead time, numbers each accepted trigger with a token, then handshakes it to readout.
//  Keeps saturating accepted/lost counters for slow control. Sits between the sum trigger logic and the readout arbiter.
// PARAMETERS
//  TOKW        16     token / counter width
//  DTW         8      dead-time register width (clk cycles)
//  ACK_TMO     255    max cycles trig_req waits for trig_ack before abandoning
// PORTS
//  clk         in   1      master clock (single clock domain)
//  reset       in   1      synchronous, active-high reset
//  trigin      in   1      trigger request pulse (1 clk) from 64-ch sum logic
//  enable      in   1      global trigger enable (slow control)
//  deadtime    in   DTW    dead time after each handshake, cycles
//  token_clr   in   1      clears token and both counters (1-clk pulse)
//  trig_req    out  1      trigger request to readout, held until ack/timeout
//  trig_ack    in   1      readout acknowledge (level or pulse)
//  token       out  TOKW   number of current/last issued trigger
//  acc_cnt     out  TOKW   accepted-trigger counter, saturating
//  lost_cnt    out  TOKW   rejected-trigger counter, saturating
//  tmo_flag    out  1      sticky: a handshake timed out; cleared by token_clr
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0.
//  FSM IDLE -> ISSUE -> DEAD -> IDLE:
//   - IDLE:  trigin & enable -> ISSUE next clk; trig_req=1 same edge; token, acc_cnt += 1 on the same edge.
//            Latency trigin -> trig_req is 1 clk.
//   - ISSUE: trig_req held high.
//            trig_ack sampled 1 -> trig_req=0 next clk, go DEAD.
//            Wait counter reaches ACK_TMO with no ack -> trig_req=0, tmo_flag=1, go DEAD.
//   - DEAD:  counter loads deadtime on entry and decrements. At 0 -> IDLE.
//            deadtime==0 -> DEAD lasts exactly 1 clk.
//  Rejection: trigin while state!=IDLE, or while enable=0, -> lost_cnt += 1.
//  Counters saturate at all-ones; no wrap.
//  token wraps at 2^TOKW-1 -> 0, because readout tracks it modulo.
//  trig_ack outside ISSUE is ignored.
//  Simultaneous events:
//   - trigin and trig_ack in the same ISSUE cycle: ack is taken, trigin is counted lost.
//   - token_clr with trigin in IDLE: clear wins for token and counters; the trigger is still issued with token=0,
//     acc_cnt=0 (clear has priority over increment).
//  enable deasserted in ISSUE/DEAD: the current sequence completes normally.
//  deadtime is sampled only on DEAD entry.
//  reset mid-operation: trig_req drops on the next edge and the FSM returns to IDLE; no ack is expected afterwards.
// CONFIGURATION
//  TRIG_PRESCALE_EN defined:
//   - adds input port prescale[7:0].
//   - An IDLE-state qualified trigger is issued only when an internal 8-bit prescale counter equals prescale;
//     that counter then reloads 0.
//   - Non-issued qualified triggers increment the counter, and neither acc_cnt nor lost_cnt.
//   - prescale==0 means issue every trigger. The counter clears on reset and token_clr.
//  Not defined: no prescale port; every qualified trigger in IDLE is issued.
// STRUCTURE
//  Shared package trig_pkg: FSM state encoding (ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_DEAD=2'd2), TOKW default,
//  ACK_TMO default.
//  One sub-module sat_counter (WIDTH param; inc, clr inputs; clr priority; saturating), instanced for acc_cnt and
//  lost_cnt.
//  The wait/dead counters share one DTW/8-bit down/up counter inside the FSM.
// TESTING
//  1. enable=1, deadtime=4, trigin pulse, trig_ack 3 clks after trig_req
//     -> trig_req high 1 clk after trigin, low 1 clk after ack; token=1, acc_cnt=1; IDLE 5 clks after req drop.
//  2. Second trigin 2 clks after first, during ISSUE -> lost_cnt=1, token stays 1, no second trig_req.
//  3. trig_ack never asserted, ACK_TMO=255 -> trig_req falls after 255 clks, tmo_flag=1, FSM returns IDLE after dead time.
//  4. enable=0, 10 trigin pulses -> no trig_req, lost_cnt=10; token_clr -> all counters 0, tmo_flag 0.
//  5. Preload token=16'hFFFF, acc_cnt=lost_cnt=16'hFFFF; trigger -> token=0, acc_cnt stays FFFF;
//     reject -> lost_cnt stays FFFF.
//  6. TRIG_PRESCALE_EN with prescale=3, 8 spaced triggers -> exactly 2 trig_req (4th, 8th); lost_cnt=0.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared definitions for the trigger sequencer: FSM state encoding and parameter defaults.
package trig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DEAD  = 2'd2
    } trig_state_e;

    localparam int unsigned TOKW_DEF    = 16;
    localparam int unsigned DTW_DEF     = 8;
    localparam int unsigned ACK_TMO_DEF = 255;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/trig_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/trig_sequencer.sv
// Trigger sequencer: qualifies sum-trigger pulses, tokens them and handshakes to readout.
// Optional TRIG_PRESCALE_EN adds a prescale input that issues one in every (prescale+1) qualified triggers.
module trig_sequencer
    import trig_pkg::*;
#(
    parameter int unsigned TOKW    = TOKW_DEF,
    parameter int unsigned DTW     = DTW_DEF,
    parameter int unsigned ACK_TMO = ACK_TMO_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            trigin,
    input  logic            enable,
    input  logic [DTW-1:0]  deadtime,
    input  logic            token_clr,
    output logic            trig_req,
    input  logic            trig_ack,
    output logic [TOKW-1:0] token,
    output logic [TOKW-1:0] acc_cnt,
    output logic [TOKW-1:0] lost_cnt,
`ifdef TRIG_PRESCALE_EN
    input  logic [7:0]      prescale,
`endif
    output logic            tmo_flag
);

    // One counter serves as ack-wait up-counter in ISSUE and dead-time down-counter in DEAD.
    localparam int unsigned CW = max_u(DTW, $clog2(ACK_TMO + 1));
    localparam logic [CW-1:0] TMO_LAST = CW'(ACK_TMO - 1);

    trig_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            req_q, req_d;
    logic            tmo_q, tmo_d;
    logic [TOKW-1:0] tok_q, tok_d;
    logic            fire, lost_inc, ps_hit;

`ifdef TRIG_PRESCALE_EN
    logic [7:0] ps_q, ps_d;
    assign ps_hit = (ps_q == prescale);
`else
    assign ps_hit = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        tmo_d    = tmo_q;
        tok_d    = tok_q;
        fire     = 1'b0;
        lost_inc = 1'b0;
`ifdef TRIG_PRESCALE_EN
        ps_d     = ps_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (trigin && enable) begin
`ifdef TRIG_PRESCALE_EN
                    ps_d = ps_hit ? 8'd0 : ps_q + 8'd1;
`endif
                    if (ps_hit) begin
                        fire    = 1'b1;
                        state_d = ST_ISSUE;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end else if (trigin) begin
                    lost_inc = 1'b1;
                end
            end
            ST_ISSUE: begin
                lost_inc = trigin;
                if (trig_ack || (cnt_q == TMO_LAST)) begin
                    tmo_d   = tmo_q | ~trig_ack;
                    req_d   = 1'b0;
                    state_d = ST_DEAD;
                    cnt_d   = CW'(deadtime);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DEAD: begin
                lost_inc = trigin;
                if (cnt_q == '0)
                    state_d = ST_IDLE;
                else
                    cnt_d = cnt_q - 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (token_clr) begin
            tok_d = '0;
            tmo_d = 1'b0;
`ifdef TRIG_PRESCALE_EN
            ps_d  = 8'd0;
`endif
        end else if (fire) begin
            tok_d = tok_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            tmo_q   <= 1'b0;
            tok_q   <= '0;
`ifdef TRIG_PRESCALE_EN
            ps_q    <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            tmo_q   <= tmo_d;
            tok_q   <= tok_d;
`ifdef TRIG_PRESCALE_EN
            ps_q    <= ps_d;
`endif
        end
    end

    sat_counter #(.WIDTH(TOKW)) u_acc_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (fire),
        .clr   (token_clr),
        .count (acc_cnt)
    );

    sat_counter #(.WIDTH(TOKW)) u_lost_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (lost_inc),
        .clr   (token_clr),
        .count (lost_cnt)
    );

    assign trig_req = req_q;
    assign tmo_flag = tmo_q;
    assign token    = tok_q;

endmodule
